// File: rtl/sdp_bram_ctl.sv
// sdp_bram_ctl: simple-dual-port block RAM with lane write enables, write-first bypass,
// address range protection, read-valid strobe and clear engine. Define SDP_BRAM_OREG_EN for a 2-cycle read.
module sdp_bram_ctl #(
  parameter int                DWIDTH  = 9,
  parameter int                DEPTH   = 2048,
  parameter int                AWIDTH  = 11,
  parameter int                LANES   = 1,
  parameter logic [DWIDTH-1:0] CLR_VAL = {DWIDTH{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              busy,
  input  logic              ena,
  input  logic [LANES-1:0]  wea,
  input  logic [AWIDTH-1:0] addra,
  input  logic [DWIDTH-1:0] dia,
  input  logic              enb,
  input  logic [AWIDTH-1:0] addrb,
  output logic [DWIDTH-1:0] dob,
  output logic              dob_valid
);

  localparam int LW = DWIDTH / LANES;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [AWIDTH-1:0] r_cnt;
  logic [AWIDTH-1:0] w_cnt_nx;
  logic              r_busy;

  logic [DWIDTH-1:0] r_mem [DEPTH];

  logic              w_a_in;
  logic              w_b_in;
  logic              w_wr_en;
  logic [AWIDTH-1:0] w_wr_addr;
  logic [DWIDTH-1:0] w_wr_data;
  logic [LANES-1:0]  w_wr_mask;
  logic              w_rd_en;
  logic [DWIDTH-1:0] w_rd_data;
  logic [DWIDTH-1:0] r_dob1;
  logic              r_valid1;

  function automatic logic [DWIDTH-1:0] lane_merge(
    input logic [DWIDTH-1:0] old_v,
    input logic [DWIDTH-1:0] new_v,
    input logic [LANES-1:0]  mask
  );
    logic [DWIDTH-1:0] res;
    res = old_v;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) begin
        res[i*LW +: LW] = new_v[i*LW +: LW];
      end else begin
        res[i*LW +: LW] = old_v[i*LW +: LW];
      end
    end
    return res;
  endfunction

  // When the address space exactly fits the array every address is legal.
  generate
    if (DEPTH >= (2 ** AWIDTH)) begin : g_full_range
      assign w_a_in = 1'b1;
      assign w_b_in = 1'b1;
    end else begin : g_part_range
      assign w_a_in = (32'(addra) < 32'(DEPTH));
      assign w_b_in = (32'(addrb) < 32'(DEPTH));
    end
  endgenerate

  // Clear/run sequencing and clear address counter.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      ST_CLEAR: begin
        if (clr) begin
          w_cnt_nx = {AWIDTH{1'b0}};
        end else if (r_cnt == AWIDTH'(DEPTH - 1)) begin
          w_state_nx = ST_RUN;
          w_cnt_nx   = {AWIDTH{1'b0}};
        end else begin
          w_cnt_nx = r_cnt + {{(AWIDTH-1){1'b0}}, 1'b1};
        end
      end
      ST_RUN: begin
        if (clr) begin
          w_state_nx = ST_CLEAR;
          w_cnt_nx   = {AWIDTH{1'b0}};
        end else begin
          w_state_nx = ST_RUN;
        end
      end
      default: begin
        w_state_nx = ST_CLEAR;
        w_cnt_nx   = {AWIDTH{1'b0}};
      end
    endcase
  end

  // State register; busy is registered from the next state so it changes on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_cnt   <= {AWIDTH{1'b0}};
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_busy  <= (w_state_nx == ST_CLEAR);
    end
  end

  // Write port arbitration: a clr pulse suppresses every write on its edge.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = r_cnt;
    w_wr_data = CLR_VAL;
    w_wr_mask = {LANES{1'b1}};
    if (clr) begin
      w_wr_en = 1'b0;
    end else if (r_state == ST_CLEAR) begin
      w_wr_en = 1'b1;
    end else if (ena && w_a_in && (|wea)) begin
      w_wr_en   = 1'b1;
      w_wr_addr = addra;
      w_wr_data = dia;
      w_wr_mask = wea;
    end else begin
      w_wr_en = 1'b0;
    end
  end

  // Array write, lane by lane; the array has no reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_wr_mask[i]) begin
          r_mem[w_wr_addr][i*LW +: LW] <= w_wr_data[i*LW +: LW];
        end
      end
    end
  end

  assign w_rd_en = enb && !clr && (r_state == ST_RUN);

  // Read data with write-first bypass; out-of-range reads return zero.
  always_comb begin
    w_rd_data = {DWIDTH{1'b0}};
    if (!w_b_in) begin
      w_rd_data = {DWIDTH{1'b0}};
    end else if (ena && w_a_in && (addra == addrb)) begin
      w_rd_data = lane_merge(r_mem[addrb], dia, wea);
    end else begin
      w_rd_data = r_mem[addrb];
    end
  end

  // First output stage: dob holds when no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dob1   <= {DWIDTH{1'b0}};
      r_valid1 <= 1'b0;
    end else if (w_rd_en) begin
      r_dob1   <= w_rd_data;
      r_valid1 <= 1'b1;
    end else begin
      r_valid1 <= 1'b0;
    end
  end

`ifdef SDP_BRAM_OREG_EN
  logic [DWIDTH-1:0] r_dob2;
  logic              r_valid2;

  // Optional second output stage, data and strobe delayed together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dob2   <= {DWIDTH{1'b0}};
      r_valid2 <= 1'b0;
    end else begin
      r_dob2   <= r_dob1;
      r_valid2 <= r_valid1;
    end
  end

  assign dob       = r_dob2;
  assign dob_valid = r_valid2;
`else
  assign dob       = r_dob1;
  assign dob_valid = r_valid1;
`endif

  assign busy = r_busy;

endmodule

// File: tb/tb_sdp_bram_ctl.sv
// Bench for sdp_bram_ctl: a default instance and a 2-lane/1000-word instance, both
// compared every cycle against an array-based reference model.
module tb_sdp_bram_ctl;

  localparam int D1 = 2048;
  localparam int D2 = 1000;
`ifdef SDP_BRAM_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        c1_clr, c1_ena, c1_enb;
  logic [0:0]  c1_wea;
  logic [10:0] c1_addra, c1_addrb;
  logic [8:0]  c1_dia, o1_dob;
  logic        o1_busy, o1_valid;

  logic        c2_clr, c2_ena, c2_enb;
  logic [1:0]  c2_wea;
  logic [9:0]  c2_addra, c2_addrb;
  logic [7:0]  c2_dia, o2_dob;
  logic        o2_busy, o2_valid;

  int n_assert = 0;
  int n_fail   = 0;

  int mem [2][2048];
  int clear_left [2];
  int s1_dob [2];
  int s1_v   [2];
  int po_dob [2];
  int po_v   [2];

  sdp_bram_ctl u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(c1_clr), .busy(o1_busy),
    .ena(c1_ena), .wea(c1_wea), .addra(c1_addra), .dia(c1_dia),
    .enb(c1_enb), .addrb(c1_addrb), .dob(o1_dob), .dob_valid(o1_valid)
  );

  sdp_bram_ctl #(.DWIDTH(8), .DEPTH(D2), .AWIDTH(10), .LANES(2), .CLR_VAL(8'h5A)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clr(c2_clr), .busy(o2_busy),
    .ena(c2_ena), .wea(c2_wea), .addra(c2_addra), .dia(c2_dia),
    .enb(c2_enb), .addrb(c2_addrb), .dob(o2_dob), .dob_valid(o2_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int k, input int depth);
    clear_left[k] = depth;
    s1_dob[k] = 0; s1_v[k] = 0;
    po_dob[k] = 0; po_v[k] = 0;
  endtask

  // One rising edge of a memory seen as: clear countdown, else read-then-write with bypass.
  task automatic model_edge(input int k, input int depth, input int lanes, input int lw,
                            input int clrval, input bit c, input bit ea, input int we,
                            input int aa, input int da, input bit eb, input int ab);
    int mrg;
    int msk;
    po_dob[k] = s1_dob[k];
    po_v[k]   = s1_v[k];
    if (c) begin
      clear_left[k] = depth;
      s1_v[k] = 0;
    end else if (clear_left[k] > 0) begin
      clear_left[k]--;
      if (clear_left[k] == 0) begin
        for (int j = 0; j < depth; j++) mem[k][j] = clrval;
      end
      s1_v[k] = 0;
    end else begin
      mrg = (aa < depth) ? mem[k][aa] : 0;
      for (int i = 0; i < lanes; i++) begin
        if (we[i]) begin
          msk = ((1 << lw) - 1) << (i * lw);
          mrg = (mrg & ~msk) | (da & msk);
        end
      end
      if (eb) begin
        if (ab >= depth) s1_dob[k] = 0;
        else if (ea && ab == aa) s1_dob[k] = mrg;
        else s1_dob[k] = mem[k][ab];
        s1_v[k] = 1;
      end else begin
        s1_v[k] = 0;
      end
      if (ea && aa < depth) mem[k][aa] = mrg;
    end
  endtask

  function automatic int exp_dob(input int k);
`ifdef SDP_BRAM_OREG_EN
    return po_dob[k];
`else
    return s1_dob[k];
`endif
  endfunction

  function automatic int exp_v(input int k);
`ifdef SDP_BRAM_OREG_EN
    return po_v[k];
`else
    return s1_v[k];
`endif
  endfunction

  task automatic check_all(input string tag);
    chk($sformatf("%s/d1.busy", tag), 32'(o1_busy), 32'(clear_left[0] > 0));
    chk($sformatf("%s/d1.dob", tag), 32'(o1_dob), exp_dob(0));
    chk($sformatf("%s/d1.valid", tag), 32'(o1_valid), exp_v(0));
    chk($sformatf("%s/d2.busy", tag), 32'(o2_busy), 32'(clear_left[1] > 0));
    chk($sformatf("%s/d2.dob", tag), 32'(o2_dob), exp_dob(1));
    chk($sformatf("%s/d2.valid", tag), 32'(o2_valid), exp_v(1));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    if (!rst_n) begin
      model_reset(0, D1);
      model_reset(1, D2);
    end else begin
      model_edge(0, D1, 1, 9, 0, c1_clr, c1_ena, int'(c1_wea), int'(c1_addra),
                 int'(c1_dia), c1_enb, int'(c1_addrb));
      model_edge(1, D2, 2, 4, 32'h5A, c2_clr, c2_ena, int'(c2_wea), int'(c2_addra),
                 int'(c2_dia), c2_enb, int'(c2_addrb));
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle();
    c1_clr = 1'b0; c1_ena = 1'b0; c1_wea = 1'b0; c1_addra = 11'd0; c1_dia = 9'd0;
    c1_enb = 1'b0; c1_addrb = 11'd0;
    c2_clr = 1'b0; c2_ena = 1'b0; c2_wea = 2'b00; c2_addra = 10'd0; c2_dia = 8'd0;
    c2_enb = 1'b0; c2_addrb = 10'd0;
  endtask

  task automatic rd1(input string tag, input int a, input int exp);
    c1_enb = 1'b1; c1_addrb = 11'(a);
    cycle(tag);
    c1_enb = 1'b0; c1_ena = 1'b0;
    repeat (LAT - 1) cycle(tag);
    chk({tag, ".dob"}, 32'(o1_dob), exp);
    chk({tag, ".valid"}, 32'(o1_valid), 32'd1);
  endtask

  task automatic rd2(input string tag, input int a, input int exp);
    c2_enb = 1'b1; c2_addrb = 10'(a);
    cycle(tag);
    c2_enb = 1'b0; c2_ena = 1'b0;
    repeat (LAT - 1) cycle(tag);
    chk({tag, ".dob"}, 32'(o2_dob), exp);
    chk({tag, ".valid"}, 32'(o2_valid), 32'd1);
  endtask

  task automatic wait_clear1(input string tag);
    int n;
    int v_seen;
    n = 0;
    v_seen = 0;
    while (o1_busy === 1'b1 && n < 3000) begin
      cycle(tag);
      v_seen = v_seen | int'(o1_valid);
      n++;
    end
    chk({tag, ".len"}, n, D1);
    chk({tag, ".no_valid"}, v_seen, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset(0, D1);
    model_reset(1, D2);
    repeat (3) cycle("reset");
    rst_n = 1'b1;
    wait_clear1("clear");

    rd1("rd0", 0, 0);
    rd1("rd1023", 1023, 0);
    rd1("rd2047", 2047, 0);

    c1_ena = 1'b1; c1_wea = 1'b1; c1_addra = 11'd0; c1_dia = 9'd125;
    cycle("wr0");
    c1_ena = 1'b0;
    cycle("gap");
    rd1("rd_w0", 0, 125);
    rd1("rd_a1", 1, 0);

    c1_ena = 1'b1; c1_wea = 1'b1; c1_addra = 11'd5; c1_dia = 9'h1AA;
    rd1("coll1", 5, 32'h1AA);
    rd1("coll1_after", 5, 32'h1AA);

    c2_ena = 1'b1; c2_wea = 2'b11; c2_addra = 10'd5; c2_dia = 8'h34;
    cycle("pre34");
    c2_wea = 2'b10; c2_dia = 8'hCD;
    rd2("lane", 5, 32'hC4);
    rd2("lane_after", 5, 32'hC4);

    c2_ena = 1'b1; c2_wea = 2'b11; c2_addra = 10'd1000; c2_dia = 8'hFF;
    cycle("oor_wr");
    c2_ena = 1'b0;
    rd2("oor_rd1000", 1000, 0);
    rd2("oor_rd999", 999, 32'h5A);
    c2_ena = 1'b1; c2_wea = 2'b11; c2_addra = 10'd1023; c2_dia = 8'hFF;
    rd2("oor_coll", 1023, 0);

    c1_clr = 1'b1; c1_ena = 1'b1; c1_wea = 1'b1; c1_addra = 11'd3; c1_dia = 9'h77;
    c1_enb = 1'b1; c1_addrb = 11'd3;
    cycle("clr_run");
    chk("clr_busy_rise", 32'(o1_busy), 32'd1);
    c1_clr = 1'b0;
    repeat (100) cycle("clr_gate");
    c1_clr = 1'b1;
    cycle("clr_restart");
    c1_clr = 1'b0;
    wait_clear1("clr_gate");
    c1_ena = 1'b0; c1_enb = 1'b0;
    rd1("gate_rd3", 3, 0);

    for (int t = 0; t < 800; t++) begin
      c1_ena = 1'($urandom_range(0, 1));
      c1_wea = 1'($urandom_range(0, 1));
      c1_addra = 11'($urandom_range(0, 15));
      c1_dia = 9'($urandom);
      c1_enb = 1'($urandom_range(0, 1));
      c1_addrb = 11'($urandom_range(0, 15));
      c2_clr = ($urandom_range(0, 299) == 0);
      c2_ena = 1'($urandom_range(0, 1));
      c2_wea = 2'($urandom_range(0, 3));
      c2_addra = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(990, 1023));
      c2_dia = 8'($urandom);
      c2_enb = 1'($urandom_range(0, 1));
      c2_addrb = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(990, 1023));
      cycle("rand");
    end

    idle();
    c1_ena = 1'b1; c1_wea = 1'b1; c1_addra = 11'd0; c1_dia = 9'h155;
    cycle("pre_rst_wr");
    c1_ena = 1'b0; c1_enb = 1'b1; c1_addrb = 11'd0; c2_enb = 1'b1; c2_addrb = 10'd5;
    cycle("pre_rst_rd");
    rst_n = 1'b0;
    model_reset(0, D1);
    model_reset(1, D2);
    #1;
    check_all("rst_async");
    chk("rst_async.d1dob", 32'(o1_dob), 32'd0);
    idle();
    #3;
    cycle("rst_hold");
    rst_n = 1'b1;
    wait_clear1("clear2");
    rd1("post_rst_rd0", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sdp_bram_ctl.md
# sdp_bram_ctl

Parametrised simple-dual-port block RAM with one write port (A) and one read port (B) on a single clock, the successor to `sdp_bram`. It adds:
- per-lane write enables;
- write-first collision bypass;
- out-of-range address protection;
- a read-valid strobe;
- a hardware clear engine that fills the array with a constant after reset or on request.

It sits between the calculator datapath and the on-chip memory, replacing direct `sdp_bram` instances.

## Interface
- `DWIDTH`, 9, data width in bits; must be divisible by `LANES`.
- `DEPTH`, 2048, number of words; must be ≤ 2^`AWIDTH`.
- `AWIDTH`, 11, address width.
- `LANES`, 1, number of write-enable lanes; lane width is `DWIDTH`/`LANES`.
- `CLR_VAL`, 0, `DWIDTH`-bit value written to every word by the clear engine.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  one-cycle pulse; starts or restarts a clear.
- `busy`  out  1  high while the clear engine owns the array.
- `ena`  in  1  port A enable.
- `wea`  in  `LANES`  per-lane write enable; qualified by `ena`.
- `addra`  in  `AWIDTH`  write address.
- `dia`  in  `DWIDTH`  write data.
- `enb`  in  1  port B read enable.
- `addrb`  in  `AWIDTH`  read address.
- `dob`  out  `DWIDTH`  read data.
- `dob_valid`  out  1  one-cycle strobe marking new `dob`.

## Operation
- **FSM states:** CLEAR, RUN.
  - Reset enters CLEAR with the clear counter at 0.
  - CLEAR writes `CLR_VAL` to address counter, incrementing once per cycle. After writing `DEPTH`-1 it moves to RUN.
  - In RUN, `clr`=1 returns to CLEAR with the counter at 0.
  - In CLEAR, `clr`=1 restarts the counter at 0.
- **CLEAR:** `busy`=1. `ena` and `enb` are ignored: no user writes, `dob_valid` stays 0, and `dob` holds its value.
- **RUN:** `busy`=0.
- **Write:**
  - When `ena`=1, every lane i with `wea[i]`=1 writes `dia` lane i to `addra`; lanes with `wea[i]`=0 keep their old contents.
  - `ena`=0 or `wea`=0 means no write.
- **Read:** when `enb`=1, the word at `addrb` is presented on `dob`, with `dob_valid`=1 for exactly one cycle. When `enb`=0, `dob` holds and `dob_valid`=0.
- **Collision** (`ena`&`enb`, same in-range address, same cycle): write-first. `dob` returns the merged word: lanes with `wea` set take `dia`, the other lanes take the old contents.
- **Out of range** (address ≥ `DEPTH`):
  - A write is dropped.
  - A read returns all-zeros, with `dob_valid`=1 still asserted.
- The array itself is not reset by `rst_n`; only the clear engine initialises it.

## Timing
- **Reset values:** `dob`=0, `dob_valid`=0, `busy`=1.
- **Clear duration:** after `rst_n` rises, `busy` stays high for exactly `DEPTH` rising edges and drops on the edge that writes the last address.
  - After a `clr` pulse sampled in RUN, `busy` rises on that same edge and the clear takes `DEPTH` cycles.
- **Read latency:** 1 cycle. `enb` sampled at edge t gives `dob`/`dob_valid` updated at edge t.
- **Write latency:** a write at edge t is readable by a read sampled at edge t (via the bypass) or later.
- **Simultaneous events:**
  - `clr` on the same edge as a user access: `clr` wins and the access is dropped.
  - `rst_n` asserted mid-clear or mid-read: outputs go to their reset values immediately and the clear restarts from 0 on release.

## Configuration
- **`SDP_BRAM_OREG_EN`** defined: an extra output register stage is inserted.
  - Read latency becomes 2 cycles; `dob` and `dob_valid` are delayed together.
  - Reset value of the pipeline register is 0.
  - Collision and out-of-range rules are unchanged; they are resolved in the first stage.
- **Undefined:** single-stage, 1-cycle latency as described above.

## Test plan
All scenarios use the defaults (`DWIDTH`=9, `DEPTH`=2048, `AWIDTH`=11, `CLR_VAL`=0) unless stated.

- **Reset and clear:** release `rst_n`, then read addresses 0, 1023 and 2047 after `busy` falls → `busy` high for exactly 2048 cycles; each read gives `dob`=0 with `dob_valid`=1 one cycle later.
- **Basic write/read:** write `dia`=125 at `addra`=0, then read `addrb`=0 two cycles later → `dob`=125 and `dob_valid`=1 for one cycle. A read of address 1 returns 0.
- **Collision and lanes:**
  - With `LANES`=1, write 9'h1AA and read address 5 in the same cycle → `dob`=9'h1AA on the next edge.
  - With `DWIDTH`=8 and `LANES`=2, preload 8'h34 at address 5, then write 8'hCD with `wea`=2'b10 while reading address 5 → `dob`=8'hC4.
- **Out of range:** `DEPTH`=1000, `AWIDTH`=10. Write 9'h0FF to address 1000, then read addresses 1000 and 999 → both return 0 and the array is unchanged.
- **Busy gating:** pulse `clr` in RUN, and assert `enb` and a write to address 3 during `busy` → `dob_valid` stays 0 and the write is dropped. After `busy` falls, address 3 reads `CLR_VAL`.
- **Pipeline option:** with `SDP_BRAM_OREG_EN` defined, write 125 at address 0 and then read it → `dob`=125 arrives 2 cycles after `enb` is sampled. Assert `rst_n` mid-pipeline → `dob`=0 and `dob_valid`=0 immediately.
